// File: rtl/rv32i_ctrl_pkg.sv
// Shared types for the RV32I pipeline control slice.
// Stage indices, enable width and controller FSM encoding.
package rv32i_ctrl_pkg;

  localparam int PEN_W = 5;

  localparam int ST_F = 0;
  localparam int ST_D = 1;
  localparam int ST_E = 2;
  localparam int ST_M = 3;
  localparam int ST_W = 4;

  localparam logic [PEN_W-1:0] PEN_ALL = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_BRANCH,
    ACT_LU,
    ACT_STARVE,
    ACT_GO
  } act_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> stall/flush controller bundle.
// master = pipeline datapath side, slave = controller.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  import rv32i_ctrl_pkg::*;

  logic             ifetch_vld;
  logic [4:0]       dec_ra1;
  logic [4:0]       dec_ra2;
  logic             dec_ra1_zero;
  logic             dec_ra2_zero;
  logic             exe_is_load;
  logic [4:0]       exe_rad;
  logic             exe_rad_zero;
  logic             exe_branch;
  logic             mem_req;
  logic             mem_rdy;
  logic [PEN_W-1:0] pen;
  logic [PEN_W-1:0] bubble;
  logic             redirect;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ifetch_vld, dec_ra1, dec_ra2,
    output dec_ra1_zero, dec_ra2_zero,
    output exe_is_load, exe_rad, exe_rad_zero,
    output exe_branch, mem_req, mem_rdy,
    input  pen, bubble, redirect, state,
    input  stall_cnt
  );

  modport slave (
    input  ifetch_vld, dec_ra1, dec_ra2,
    input  dec_ra1_zero, dec_ra2_zero,
    input  exe_is_load, exe_rad, exe_rad_zero,
    input  exe_branch, mem_req, mem_rdy,
    output pen, bubble, redirect, state,
    output stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: decode source vs. execute load destination.
// Pure combinational; shared with the forwarding unit.
module hazard_detect (
  input  logic [4:0] ra1,
  input  logic [4:0] ra2,
  input  logic       ra1_zero,
  input  logic       ra2_zero,
  input  logic       is_load,
  input  logic [4:0] rad,
  input  logic       rad_zero,
  output logic       lu_haz
);

  logic m1;
  logic m2;

  assign m1 = (ra1 == rad) & ~ra1_zero;
  assign m2 = (ra2 == rad) & ~ra2_zero;

  assign lu_haz = is_load & ~rad_zero & (m1 | m2);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Priority: mem wait > taken branch > load-use > fetch starve.
module pipe_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        clr,
  pipe_ctrl_if.slave  bus
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  act_e             act;
  logic             mem_hold;
  logic             lu_haz;
  logic             in_redir;
  logic [PEN_W-1:0] pen_c;
  logic [PEN_W-1:0] bub_c;
  logic             redir_c;

  hazard_detect u_hd (
    .ra1      (bus.dec_ra1),
    .ra2      (bus.dec_ra2),
    .ra1_zero (bus.dec_ra1_zero),
    .ra2_zero (bus.dec_ra2_zero),
    .is_load  (bus.exe_is_load),
    .rad      (bus.exe_rad),
    .rad_zero (bus.exe_rad_zero),
    .lu_haz   (lu_haz)
  );

  assign mem_hold = bus.mem_req & ~bus.mem_rdy;
  assign in_redir = (state_q == REDIRECT);

  // Exe and decode hold bubbles in REDIRECT, so branch/hazard are ignored there.
  always_comb begin
    act = ACT_GO;
    if (mem_hold)
      act = ACT_HOLD;
    else if (bus.exe_branch && !in_redir)
      act = ACT_BRANCH;
    else if (lu_haz && !in_redir)
      act = ACT_LU;
    else if (!bus.ifetch_vld)
      act = ACT_STARVE;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (act)
      ACT_HOLD:   state_d = in_redir ? REDIRECT : MEM_WAIT;
      ACT_BRANCH: state_d = REDIRECT;
      ACT_LU:     state_d = RUN;
      ACT_STARVE: state_d = in_redir ? REDIRECT : RUN;
      ACT_GO:     state_d = RUN;
      default:    state_d = RUN;
    endcase
  end

  always_comb begin
    pen_c   = '0;
    bub_c   = '0;
    redir_c = 1'b0;
    if (clr) begin
      pen_c = PEN_ALL;
      unique case (act)
        ACT_HOLD: pen_c = '0;
        ACT_BRANCH: begin
          bub_c[ST_D] = 1'b1;
          bub_c[ST_E] = 1'b1;
          redir_c     = 1'b1;
        end
        ACT_LU: begin
          pen_c[ST_F] = 1'b0;
          pen_c[ST_D] = 1'b0;
          bub_c[ST_E] = 1'b1;
        end
        ACT_STARVE: begin
          pen_c[ST_F] = 1'b0;
          bub_c[ST_D] = 1'b1;
        end
        ACT_GO: pen_c = PEN_ALL;
        default: pen_c = PEN_ALL;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pen_c != PEN_ALL && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  assign bus.pen       = pen_c;
  assign bus.bubble    = bub_c;
  assign bus.redirect  = redir_c;
  assign bus.state     = state_q;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: per-cycle expected outputs
// are queued on drive and popped after the combinational settle.
module tb_pipe_ctrl;
  import rv32i_ctrl_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) bus ();
  pipe_ctrl_if #(.CNT_W(4))  sbus ();

  pipe_ctrl #(.CNT_W(16)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  pipe_ctrl #(.CNT_W(4)) u_sat (
    .clk (clk),
    .clr (clr),
    .bus (sbus.slave)
  );

  localparam logic [4:0] P_ALL = 5'b11111;
  localparam logic [4:0] P_LU  = 5'b11100;
  localparam logic [4:0] P_ST  = 5'b11110;
  localparam logic [4:0] P_0   = 5'b00000;
  localparam logic [4:0] B_0   = 5'b00000;
  localparam logic [4:0] B_BR  = 5'b00110;
  localparam logic [4:0] B_LU  = 5'b00100;
  localparam logic [4:0] B_ST  = 5'b00010;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_RD  = 2'd2;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt;
  logic [28:0] sb[$];
  logic [8:0]  ssb[$];
  logic [28:0] e;
  logic [8:0]  se;

  function automatic logic [28:0] obs();
    return {bus.pen, bus.bubble, bus.redirect,
            bus.state, bus.stall_cnt};
  endfunction

  task automatic idle();
    bus.ifetch_vld   = 1'b1;
    bus.dec_ra1      = 5'd0;
    bus.dec_ra2      = 5'd0;
    bus.dec_ra1_zero = 1'b0;
    bus.dec_ra2_zero = 1'b0;
    bus.exe_is_load  = 1'b0;
    bus.exe_rad      = 5'd0;
    bus.exe_rad_zero = 1'b0;
    bus.exe_branch   = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_rdy      = 1'b0;
  endtask

  task automatic sidle();
    sbus.ifetch_vld   = 1'b1;
    sbus.dec_ra1      = 5'd0;
    sbus.dec_ra2      = 5'd0;
    sbus.dec_ra1_zero = 1'b0;
    sbus.dec_ra2_zero = 1'b0;
    sbus.exe_is_load  = 1'b0;
    sbus.exe_rad      = 5'd0;
    sbus.exe_rad_zero = 1'b0;
    sbus.exe_branch   = 1'b0;
    sbus.mem_req      = 1'b0;
    sbus.mem_rdy      = 1'b0;
  endtask

  // Expected stall count advances whenever any stage is held.
  task automatic push(input logic [4:0] p, input logic [4:0] b,
                      input logic r, input logic [1:0] s);
    sb.push_back({p, b, r, s, exp_cnt});
    if (p != P_ALL && exp_cnt != 16'hffff)
      exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        clr = 1'b0;
        bus.ifetch_vld   = 1'($urandom);
        bus.dec_ra1      = 5'($urandom);
        bus.dec_ra2      = 5'($urandom);
        bus.dec_ra1_zero = 1'($urandom);
        bus.dec_ra2_zero = 1'($urandom);
        bus.exe_is_load  = 1'($urandom);
        bus.exe_rad      = 5'($urandom);
        bus.exe_rad_zero = 1'($urandom);
        bus.exe_branch   = 1'($urandom);
        bus.mem_req      = 1'($urandom);
        bus.mem_rdy      = 1'($urandom);
        sb.push_back({P_0, B_0, 1'b0, S_RUN, 16'd0});
      end else begin
        idle();
        clr = 1'b1;
        exp_cnt = 16'd0;
        push(P_ALL, B_0, 1'b0, S_RUN);
      end
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got %h want %h", i, obs(), e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 8; i++) begin
      idle();
      case (i)
        0: begin
          bus.exe_is_load = 1'b1; bus.exe_rad = 5'd5;
          bus.dec_ra2 = 5'd5;
          push(P_LU, B_LU, 1'b0, S_RUN);
        end
        1: push(P_ALL, B_0, 1'b0, S_RUN);
        2: begin
          bus.exe_is_load = 1'b1; bus.exe_rad = 5'd5;
          bus.dec_ra2 = 5'd5; bus.dec_ra2_zero = 1'b1;
          push(P_ALL, B_0, 1'b0, S_RUN);
        end
        3: begin
          bus.exe_is_load = 1'b1; bus.exe_rad = 5'd7;
          bus.dec_ra1 = 5'd7; bus.dec_ra2 = 5'd3;
          push(P_LU, B_LU, 1'b0, S_RUN);
        end
        4: begin
          bus.exe_is_load = 1'b1; bus.exe_rad = 5'd7;
          bus.dec_ra1 = 5'd7; bus.exe_rad_zero = 1'b1;
          push(P_ALL, B_0, 1'b0, S_RUN);
        end
        5: begin
          bus.exe_rad = 5'd7; bus.dec_ra1 = 5'd7;
          push(P_ALL, B_0, 1'b0, S_RUN);
        end
        6: begin
          bus.ifetch_vld = 1'b0;
          push(P_ST, B_ST, 1'b0, S_RUN);
        end
        default: begin
          bus.ifetch_vld = 1'b0;
          bus.exe_is_load = 1'b1; bus.exe_rad = 5'd9;
          bus.dec_ra1 = 5'd9;
          push(P_LU, B_LU, 1'b0, S_RUN);
        end
      endcase
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d] got %h want %h", i, obs(), e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin
        bus.mem_req = 1'b1;
        push(P_0, B_0, 1'b0, (i == 0) ? S_RUN : S_MW);
      end else if (i == 4) begin
        bus.mem_req = 1'b1; bus.mem_rdy = 1'b1;
        push(P_ALL, B_0, 1'b0, S_MW);
      end else begin
        push(P_ALL, B_0, 1'b0, S_RUN);
      end
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL mem_wait[%0d] got %h want %h", i, obs(), e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: begin
          bus.exe_branch = 1'b1;
          push(P_ALL, B_BR, 1'b1, S_RUN);
        end
        1, 2: begin
          bus.ifetch_vld = 1'b0;
          push(P_ST, B_ST, 1'b0, S_RD);
        end
        3: push(P_ALL, B_0, 1'b0, S_RD);
        default: push(P_ALL, B_0, 1'b0, S_RUN);
      endcase
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL branch[%0d] got %h want %h", i, obs(), e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_combined();
    for (int i = 0; i < 10; i++) begin
      idle();
      case (i)
        0, 1: begin
          bus.mem_req = 1'b1; bus.exe_branch = 1'b1;
          push(P_0, B_0, 1'b0, (i == 0) ? S_RUN : S_MW);
        end
        2: begin
          bus.mem_req = 1'b1; bus.mem_rdy = 1'b1;
          bus.exe_branch = 1'b1;
          push(P_ALL, B_BR, 1'b1, S_MW);
        end
        3: begin
          bus.mem_req = 1'b1;
          push(P_0, B_0, 1'b0, S_RD);
        end
        4: push(P_ALL, B_0, 1'b0, S_RD);
        5: begin
          bus.exe_branch = 1'b1;
          bus.exe_is_load = 1'b1; bus.exe_rad = 5'd3;
          bus.dec_ra1 = 5'd3;
          push(P_ALL, B_BR, 1'b1, S_RUN);
        end
        6: push(P_ALL, B_0, 1'b0, S_RD);
        7: begin
          bus.mem_req = 1'b1;
          push(P_0, B_0, 1'b0, S_RUN);
        end
        8: begin
          bus.mem_req = 1'b1; bus.mem_rdy = 1'b1;
          bus.exe_is_load = 1'b1; bus.exe_rad = 5'd4;
          bus.dec_ra2 = 5'd4;
          push(P_LU, B_LU, 1'b0, S_MW);
        end
        default: push(P_ALL, B_0, 1'b0, S_RUN);
      endcase
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL combined[%0d] got %h want %h", i, obs(), e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 23; i++) begin
      sidle();
      if (i < 20) begin
        sbus.mem_req = 1'b1;
        ssb.push_back({P_0, (i > 15) ? 4'd15 : 4'(i)});
      end else begin
        ssb.push_back({P_ALL, 4'd15});
      end
      #1;
      se = ssb.pop_front();
      n_run++;
      if ({sbus.pen, sbus.stall_cnt} !== se) begin
        n_fail++;
        $display("FAIL saturation[%0d] got %h want %h",
                 i, {sbus.pen, sbus.stall_cnt}, se);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    exp_cnt = 16'd0;
    idle();
    sidle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_combined();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
